// File: rtl/mcp_main_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core.
// Optional illegal-opcode trap: define MCP_ILLEGAL_TRAP_EN.
module mcp_main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

`ifdef MCP_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_set_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end

  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    w_next   = S_FETCH;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
`ifdef MCP_ILLEGAL_TRAP_EN
    w_set_illegal = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW,
          OP_SW:   w_next = S_MEMADR;
          OP_RTYP: w_next = S_EXEC;
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: begin
`ifdef MCP_ILLEGAL_TRAP_EN
            w_next        = S_TRAP;
            w_set_illegal = 1'b1;
`else
            w_next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b11;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef MCP_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mcp_main_control_fsm.sv
// Bench for mcp_main_control_fsm: directed and random
// instruction streams against an instruction-level model.
module tb_mcp_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  logic       illegal_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    bit mr;
    bit il;
  } step_t;

  typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;

  mcp_main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .Branch(Branch), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  wire [14:0] w_obs = {PCWrite, Branch, IorD, MemWrite,
                       IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSrc};

  // Control table: which outputs each state drives.
  function automatic logic [14:0] exp_ctrl(int st, bit mr);
    logic pcw, br, iord, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, op, pcs;
    {pcw, br, iord, mw, irw, rd, m2r, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin sb = 2'b01; pcw = mr; irw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; op = 2'b11; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, br, iord, mw, irw, rd, m2r, rw, sa, sb, op, pcs};
  endfunction

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] opc_of(kind_t k);
    logic [5:0] o;
    case (k)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_R:    o = 6'b000000;
      K_BEQ:  o = 6'b000100;
      K_ADDI: o = 6'b001000;
      K_J:    o = 6'b000010;
      default: begin
        o = 6'($urandom);
        while (o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02})
          o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  // Enters with time at edge+1; leaves at edge+1 in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    check("rst_state", 16'(state), 16'd0);
    check("rst_illegal", 16'(illegal_op), 16'd0);
    check("rst_ctrl", 16'(w_obs), 16'(exp_ctrl(0, mem_ready)));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(kind_t k, logic [5:0] opc, int wf, int wm);
    step_t q[$];
    bit trap;
    trap = 1'b0;
    for (int i = 0; i < wf; i++) q.push_back('{0, 1'b0, 1'b0});
    q.push_back('{0, 1'b1, 1'b0});
    q.push_back('{1, 1'($urandom), 1'b0});
    case (k)
      K_LW: begin
        q.push_back('{2, 1'($urandom), 1'b0});
        for (int i = 0; i < wm; i++) q.push_back('{3, 1'b0, 1'b0});
        q.push_back('{3, 1'b1, 1'b0});
        q.push_back('{4, 1'($urandom), 1'b0});
      end
      K_SW: begin
        q.push_back('{2, 1'($urandom), 1'b0});
        for (int i = 0; i < wm; i++) q.push_back('{5, 1'b0, 1'b0});
        q.push_back('{5, 1'b1, 1'b0});
      end
      K_R: begin
        q.push_back('{6, 1'($urandom), 1'b0});
        q.push_back('{7, 1'($urandom), 1'b0});
      end
      K_BEQ:  q.push_back('{8, 1'($urandom), 1'b0});
      K_ADDI: begin
        q.push_back('{9, 1'($urandom), 1'b0});
        q.push_back('{10, 1'($urandom), 1'b0});
      end
      K_J:    q.push_back('{11, 1'($urandom), 1'b0});
      default: begin
`ifdef MCP_ILLEGAL_TRAP_EN
        trap = 1'b1;
        for (int i = 0; i < 10; i++)
          q.push_back('{15, 1'($urandom), 1'b1});
`endif
      end
    endcase
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      opcode = (q[i].st == 1 || q[i].st == 2) ? opc : 6'($urandom);
      #1;
      check($sformatf("state k%0d c%0d", k, i), 16'(state), 16'(q[i].st));
      check($sformatf("ctrl k%0d c%0d", k, i), 16'(w_obs),
            16'(exp_ctrl(q[i].st, q[i].mr)));
      check($sformatf("illegal k%0d c%0d", k, i), 16'(illegal_op),
            16'(q[i].il));
      @(posedge clk);
      #1;
    end
    if (trap) do_reset();
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    @(posedge clk);
    #1;
    do_reset();

    // Abandon an R-type mid-EXEC with an async reset.
    mem_ready = 1'b1;
    opcode = 6'b000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("exec_reached", 16'(state), 16'd6);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_state", 16'(state), 16'd0);
    check("async_rst_rw", 16'(RegWrite), 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold_rw", 16'(RegWrite), 16'd0);
    check("rst_hold_state", 16'(state), 16'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_decode", 16'(state), 16'd1);
    do_reset();

    run_instr(K_LW, opc_of(K_LW), 0, 0);
    run_instr(K_SW, opc_of(K_SW), 0, 3);
    run_instr(K_R, opc_of(K_R), 0, 0);
    run_instr(K_BEQ, opc_of(K_BEQ), 0, 0);
    run_instr(K_ADDI, opc_of(K_ADDI), 2, 0);
    run_instr(K_J, opc_of(K_J), 0, 0);
    run_instr(K_ILL, 6'b111111, 0, 0);

    for (int n = 0; n < 60; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 6));
      run_instr(k, opc_of(k), $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    check("final_fetch", 16'(state), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp_main_control_fsm.md
# mcp_main_control_fsm

Main control state machine of the multi-cycle MIPS core, sitting directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, including the 2-bit `ALUOp` consumed by the ALU decoder. It also stalls on a memory ready handshake.

## Interface
- No parameters.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; one clock, async active-high reset, fixed.
- `opcode` input 6: `IR[31:26]` from the instruction register; valid from DECODE onward.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: unconditional PC load.
- `Branch` output 1: conditional PC load; the datapath ANDs it with ALU zero.
- `IorD` output 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `MemWrite` output 1: memory write request.
- `IRWrite` output 1: instruction register load.
- `RegDst` output 1: 1 selects rd as destination, 0 selects rt.
- `MemtoReg` output 1: 1 writes back the data register, 0 writes back ALUOut.
- `RegWrite` output 1: register file write.
- `ALUSrcA` output 1: 0 selects PC, 1 selects register A.
- `ALUSrcB` output 2: 00 selects B, 01 selects constant 4, 10 selects SignImm, 11 selects SignImm<<2.
- `ALUOp` output 2: 00 is add, 01 is sub, 11 means decode funct; 10 is never driven.
- `PCSrc` output 2: 00 selects ALUResult, 01 selects ALUOut, 10 selects the jump target.
- `state` output 4: current state, for debug.
- `illegal_op` output 1: sticky illegal-opcode flag.

## Operation
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=15.
  - Codes 12–14 are unused and go to FETCH on the next edge.
- Output rule: any output not listed for a state is 0.
- FETCH:
  - Drives IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Moves to DECODE when mem_ready=1; otherwise stays.
- DECODE: drives ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW): MEMADR.
  - 000000 (R-type): EXEC.
  - 000100 (BEQ): BRANCH.
  - 001000 (ADDI): ADDIEX.
  - 000010 (J): JUMP.
  - Any other opcode: see Configuration.
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Moves to MEMRD for LW, MEMWR for SW.
- MEMRD: drives IorD=1. Holds until mem_ready=1, then moves to MEMWB.
- MEMWB: drives RegDst=0, MemtoReg=1, RegWrite=1. Moves to FETCH.
- MEMWR: drives IorD=1 and MemWrite=1 for the whole state. Holds until mem_ready=1, then moves to FETCH.
- EXEC: drives ALUSrcA=1, ALUSrcB=00, ALUOp=11. Moves to ALUWB.
- ALUWB: drives RegDst=1, MemtoReg=0, RegWrite=1. Moves to FETCH.
- BRANCH: drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Moves to FETCH.
- ADDIEX: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Moves to ADDIWB.
- ADDIWB: drives RegDst=0, MemtoReg=0, RegWrite=1. Moves to FETCH.
- JUMP: drives PCSrc=10, PCWrite=1. Moves to FETCH.
- `opcode` is sampled only in DECODE and MEMADR; its value in other states is ignored.

## Timing
- Reset:
  - Asynchronous assert forces `state`=FETCH (0) and `illegal_op`=0 immediately.
  - While in reset, outputs show FETCH decode: IRWrite=PCWrite=mem_ready, all else as FETCH.
  - Reset mid-instruction abandons it; no RegWrite or MemWrite is issued after reset asserts.
- Registers: `state` and `illegal_op` are the only registers. All other outputs are combinational from `state`, and from `mem_ready` in FETCH only.
- Zero-wait cycle counts:
  - LW=5, SW=4, R-type=4, ADDI=4, BEQ=3, J=3.
  - Each wait cycle (mem_ready=0) in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake:
  - Memory must hold data/ack for the cycle mem_ready=1.
  - The FSM leaves the waiting state on the next clock edge.
  - mem_ready is ignored in all other states.

## Configuration
- `MCP_ILLEGAL_TRAP_EN` defined:
  - An unrecognised opcode in DECODE moves to TRAP (15) and sets `illegal_op`=1.
  - In TRAP all control outputs are 0 and the FSM stays until `reset`.
- `MCP_ILLEGAL_TRAP_EN` undefined:
  - An unrecognised opcode in DECODE returns to FETCH, acting as a 2-cycle NOP.
  - `illegal_op` is tied to 0; TRAP does not exist, and code 15 goes to FETCH.

## Test plan
- Reset asserted mid-EXEC (state=6), async → state=0 before the next edge; RegWrite never asserts. After release with mem_ready=1 → DECODE one cycle later.
- LW, opcode=100011, mem_ready=1 always → state sequence 0,1,2,3,4,0 with ALUOp 00,00,00,–,–. RegWrite=1 and MemtoReg=1 only in state 4.
- SW with mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles, then state=0; total 7 cycles.
- R-type, opcode=000000 → ALUOp=11 only in state 6. RegDst=1 and RegWrite=1 in state 7. BEQ, opcode=000100 → ALUOp=01, Branch=1, PCSrc=01 in state 8.
- FETCH with mem_ready=0 for 2 cycles → IRWrite=PCWrite=0 and state held at 0. On the cycle mem_ready=1, IRWrite=PCWrite=1; state=1 next cycle.
- Opcode=111111: with `MCP_ILLEGAL_TRAP_EN` → state=15 and illegal_op=1 held for 10 cycles until reset. Without it → state 1 then 0, illegal_op=0.
